// File: rtl/gate_sequencer.sv
// Steps through a stored gate program: fetch, decode, load the gate matrix
// from the matrix table (with timeout/retry), then run the apply unit.
module gate_sequencer #(
  parameter int NUM_QUBITS   = 4,
  parameter int ADDR_W       = 5,
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [7:0]        instr_data,
  output logic [4:0]        mtx_gate,
  output logic              mtx_ready,
  input  logic              mtx_done_pulse,
  output logic              apply_start,
  output logic [2:0]        apply_target,
  input  logic              apply_done,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   gate_count,
  output logic [3:0]        state_dbg
);

  // Handshakes: mtx_ready and apply_start are single-cycle requests. Their
  // completions (mtx_done_pulse, apply_done) are sampled only in LOAD and
  // WAIT_APPLY respectively; a completion seen in any other state is dropped.

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_REQ, S_LOAD,
    S_APPLY, S_WAIT_APPLY, S_NEXT, S_DONE
  } state_t;

  localparam logic [4:0]    GATE_NOP   = 5'h00;
  localparam logic [4:0]    GATE_HALT  = 5'h1F;
  localparam logic [3:0]    NQ         = 4'(NUM_QUBITS);
  localparam int            TW         = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_INIT = TW'(LOAD_TIMEOUT - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [ADDR_W:0]   len, len_n;
  logic [ADDR_W:0]   gc_n;
  logic [ADDR_W:0]   pc_inc;
  logic [4:0]        gate_n;
  logic [2:0]        tgt_n;
  logic              err_n;
  logic [TW-1:0]     timer, timer_n;

  assign instr_addr = pc;
  assign state_dbg  = state;
  assign pc_inc     = {1'b0, pc} + 1'b1;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    len_n   = len;
    gc_n    = gate_count;
    gate_n  = mtx_gate;
    tgt_n   = apply_target;
    err_n   = error;
    timer_n = timer;
    case (state)
      S_IDLE: begin
        if (start) begin
          len_n   = prog_len;
          pc_n    = '0;
          gc_n    = '0;
          err_n   = 1'b0;
          state_n = (prog_len == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_n = S_DECODE;
      S_DECODE: begin
        if (instr_data[7:3] == GATE_HALT) begin
          state_n = S_DONE;
        end else if (instr_data[7:3] == GATE_NOP) begin
          state_n = S_NEXT;
        end else if ({1'b0, instr_data[2:0]} >= NQ) begin
          err_n   = 1'b1;
          state_n = S_DONE;
        end else begin
          gate_n  = instr_data[7:3];
          tgt_n   = instr_data[2:0];
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        timer_n = TIMER_INIT;
        state_n = S_LOAD;
      end
      S_LOAD: begin
        // A done pulse beats an expiring timer in the same cycle.
        if (mtx_done_pulse) begin
          state_n = S_APPLY;
        end else if (timer <= TW'(1)) begin
          state_n = S_REQ;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      S_APPLY: state_n = S_WAIT_APPLY;
      S_WAIT_APPLY: begin
        if (apply_done) begin
          gc_n    = gate_count + 1'b1;
          state_n = S_NEXT;
        end
      end
      S_NEXT: begin
        // Compared at ADDR_W+1 bits so a full-depth program ends cleanly.
        if (pc_inc == len) begin
          state_n = S_DONE;
        end else begin
          pc_n    = pc + 1'b1;
          state_n = S_FETCH;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      pc           <= '0;
      len          <= '0;
      gate_count   <= '0;
      mtx_gate     <= '0;
      apply_target <= '0;
      error        <= 1'b0;
      timer        <= '0;
      mtx_ready    <= 1'b0;
      apply_start  <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      len          <= len_n;
      gate_count   <= gc_n;
      mtx_gate     <= gate_n;
      apply_target <= tgt_n;
      error        <= err_n;
      timer        <= timer_n;
      mtx_ready    <= (state_n == S_REQ);
      apply_start  <= (state_n == S_APPLY);
      done         <= (state_n == S_DONE);
      busy         <= (state_n != S_IDLE);
    end
  end

endmodule
